// File: rtl/tex_wrap_sched.sv
// Serial texture-coordinate wrap scheduler: one shared U and V wrap unit walks every
// (lane, tap) of a buffered request and presents the whole result as one response.
module tex_wrap_sched #(
    parameter int NUM_LANES = 4,
    parameter int FXD_BITS  = 32,
    parameter int FXD_FRAC  = 20,
    parameter int WRAP_BITS = 2,
    parameter int TAG_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [WRAP_BITS-1:0]          req_wrap_u,
    input  logic [WRAP_BITS-1:0]          req_wrap_v,
    input  logic                          req_filter,
    input  logic [NUM_LANES*FXD_BITS-1:0] req_u,
    input  logic [NUM_LANES*FXD_BITS-1:0] req_v,
    input  logic [FXD_BITS-1:0]           req_du,
    input  logic [FXD_BITS-1:0]           req_dv,
    input  logic [TAG_W-1:0]              req_tag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [NUM_LANES*FXD_FRAC-1:0] rsp_u0,
    output logic [NUM_LANES*FXD_FRAC-1:0] rsp_v0,
    output logic [NUM_LANES*FXD_FRAC-1:0] rsp_u1,
    output logic [NUM_LANES*FXD_FRAC-1:0] rsp_v1,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic                          busy,
    output logic [1:0]                    fsm_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WRAP = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_W-1:0]    LAST_LANE   = LANE_W'(NUM_LANES - 1);
    localparam logic [WRAP_BITS-1:0] MODE_CLAMP  = WRAP_BITS'(0);
    localparam logic [WRAP_BITS-1:0] MODE_MIRROR = WRAP_BITS'(2);

    logic [1:0]                    state;
    logic [LANE_W-1:0]             lane;
    logic                          tap;
    logic [WRAP_BITS-1:0]          mode_u;
    logic [WRAP_BITS-1:0]          mode_v;
    logic                          filter_q;
    logic [NUM_LANES*FXD_BITS-1:0] u_q;
    logic [NUM_LANES*FXD_BITS-1:0] v_q;
    logic [FXD_BITS-1:0]           du_q;
    logic [FXD_BITS-1:0]           dv_q;

    int                  lane_idx;
    logic [FXD_BITS-1:0] base_u;
    logic [FXD_BITS-1:0] base_v;
    logic [FXD_BITS-1:0] coord_u;
    logic [FXD_BITS-1:0] coord_v;
    logic [FXD_FRAC-1:0] wrapped_u;
    logic [FXD_FRAC-1:0] wrapped_v;
    logic                last_step;

    // Mode 3 (and any unlisted encoding) falls through to REPEAT.
    function automatic logic [FXD_FRAC-1:0] wrap_coord(
        input logic [WRAP_BITS-1:0] mode,
        input logic [FXD_BITS-1:0]  x
    );
        logic [FXD_FRAC-1:0] frac;
        frac = x[FXD_FRAC-1:0];
        if (mode == MODE_CLAMP) begin
            if (x[FXD_BITS-1])
                wrap_coord = '0;
            else if (|x[FXD_BITS-2:FXD_FRAC])
                wrap_coord = '1;
            else
                wrap_coord = frac;
        end else if (mode == MODE_MIRROR) begin
            wrap_coord = frac ^ {FXD_FRAC{x[FXD_FRAC]}};
        end else begin
            wrap_coord = frac;
        end
    endfunction

    always_comb begin
        lane_idx  = int'(lane);
        base_u    = u_q[lane_idx*FXD_BITS +: FXD_BITS];
        base_v    = v_q[lane_idx*FXD_BITS +: FXD_BITS];
        coord_u   = tap ? (base_u + du_q) : base_u;
        coord_v   = tap ? (base_v + dv_q) : base_v;
        wrapped_u = wrap_coord(mode_u, coord_u);
        wrapped_v = wrap_coord(mode_v, coord_v);
        last_step = (lane == LAST_LANE) && (tap || !filter_q);
    end

    // Both ports use plain valid/ready: a transfer happens on a rising clock edge where
    // valid and ready are both high; the producer holds valid and data stable until then.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            lane     <= '0;
            tap      <= 1'b0;
            mode_u   <= '0;
            mode_v   <= '0;
            filter_q <= 1'b0;
            u_q      <= '0;
            v_q      <= '0;
            du_q     <= '0;
            dv_q     <= '0;
            rsp_u0   <= '0;
            rsp_v0   <= '0;
            rsp_u1   <= '0;
            rsp_v1   <= '0;
            rsp_tag  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mode_u   <= req_wrap_u;
                        mode_v   <= req_wrap_v;
                        filter_q <= req_filter;
                        u_q      <= req_u;
                        v_q      <= req_v;
                        du_q     <= req_du;
                        dv_q     <= req_dv;
                        rsp_tag  <= req_tag;
                        lane     <= '0;
                        tap      <= 1'b0;
                        state    <= ST_WRAP;
                    end
                end
                ST_WRAP: begin
                    // Point mode mirrors tap 0 into the tap-1 slots.
                    if (!tap) begin
                        rsp_u0[lane_idx*FXD_FRAC +: FXD_FRAC] <= wrapped_u;
                        rsp_v0[lane_idx*FXD_FRAC +: FXD_FRAC] <= wrapped_v;
                        if (!filter_q) begin
                            rsp_u1[lane_idx*FXD_FRAC +: FXD_FRAC] <= wrapped_u;
                            rsp_v1[lane_idx*FXD_FRAC +: FXD_FRAC] <= wrapped_v;
                        end
                    end else begin
                        rsp_u1[lane_idx*FXD_FRAC +: FXD_FRAC] <= wrapped_u;
                        rsp_v1[lane_idx*FXD_FRAC +: FXD_FRAC] <= wrapped_v;
                    end
                    if (last_step) begin
                        state <= ST_OUT;
                    end else if (filter_q && !tap) begin
                        tap <= 1'b1;
                    end else begin
                        tap  <= 1'b0;
                        lane <= lane + LANE_W'(1);
                    end
                end
                ST_OUT: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tex_wrap_sched.sv
// Directed bench for tex_wrap_sched: hand-computed vectors feed an expected queue that a
// response monitor drains, plus timing, back-pressure and async-reset checks.
module tb_tex_wrap_sched;

    localparam int NL = 4;
    localparam int FB = 32;
    localparam int FF = 20;
    localparam int WB = 2;
    localparam int TW = 8;
    localparam int L  = NL * FF;
    localparam int EW = TW + 4 * L;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [WB-1:0] req_wrap_u;
    logic [WB-1:0] req_wrap_v;
    logic          req_filter;
    logic [NL*FB-1:0] req_u;
    logic [NL*FB-1:0] req_v;
    logic [FB-1:0] req_du;
    logic [FB-1:0] req_dv;
    logic [TW-1:0] req_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [L-1:0]  rsp_u0;
    logic [L-1:0]  rsp_v0;
    logic [L-1:0]  rsp_u1;
    logic [L-1:0]  rsp_v1;
    logic [TW-1:0] rsp_tag;
    logic          busy;
    logic [1:0]    fsm_state;

    tex_wrap_sched #(
        .NUM_LANES(NL), .FXD_BITS(FB), .FXD_FRAC(FF), .WRAP_BITS(WB), .TAG_W(TW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wrap_u(req_wrap_u), .req_wrap_v(req_wrap_v), .req_filter(req_filter),
        .req_u(req_u), .req_v(req_v), .req_du(req_du), .req_dv(req_dv), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_u0(rsp_u0), .rsp_v0(rsp_v0), .rsp_u1(rsp_u1), .rsp_v1(rsp_v1),
        .rsp_tag(rsp_tag), .busy(busy), .fsm_state(fsm_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WB-1:0]    wu;
        logic [WB-1:0]    wv;
        logic             filt;
        logic [NL*FB-1:0] u;
        logic [NL*FB-1:0] v;
        logic [FB-1:0]    du;
        logic [FB-1:0]    dv;
        logic [TW-1:0]    tag;
        logic [L-1:0]     eu0;
        logic [L-1:0]     ev0;
        logic [L-1:0]     eu1;
        logic [L-1:0]     ev1;
    } vec_t;

    vec_t vecs [6];
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: one pop per response handshake.
    always @(negedge clk) begin : mon_blk
        logic [EW-1:0] e;
        #1;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got tag %0h expected no response", rsp_tag);
            end else begin
                e = exp_q.pop_front();
                check("rsp_tag", rsp_tag, e[EW-1 -: TW]);
                check("rsp_u0",  rsp_u0,  e[4*L-1 -: L]);
                check("rsp_v0",  rsp_v0,  e[3*L-1 -: L]);
                check("rsp_u1",  rsp_u1,  e[2*L-1 -: L]);
                check("rsp_v1",  rsp_v1,  e[L-1 -: L]);
            end
        end
    end

    // Driver tasks
    task automatic set_vec(input int i, input logic [WB-1:0] wu, input logic [WB-1:0] wv,
                           input logic filt, input logic [NL*FB-1:0] u, input logic [NL*FB-1:0] v,
                           input logic [FB-1:0] du, input logic [FB-1:0] dv, input logic [TW-1:0] tag,
                           input logic [L-1:0] eu0, input logic [L-1:0] ev0,
                           input logic [L-1:0] eu1, input logic [L-1:0] ev1);
        vecs[i].wu = wu;   vecs[i].wv = wv;   vecs[i].filt = filt;
        vecs[i].u = u;     vecs[i].v = v;     vecs[i].du = du;   vecs[i].dv = dv;
        vecs[i].tag = tag; vecs[i].eu0 = eu0; vecs[i].ev0 = ev0;
        vecs[i].eu1 = eu1; vecs[i].ev1 = ev1;
    endtask

    task automatic drive_fields(input int i);
        req_wrap_u = vecs[i].wu;
        req_wrap_v = vecs[i].wv;
        req_filter = vecs[i].filt;
        req_u      = vecs[i].u;
        req_v      = vecs[i].v;
        req_du     = vecs[i].du;
        req_dv     = vecs[i].dv;
        req_tag    = vecs[i].tag;
    endtask

    task automatic scramble_fields();
        req_wrap_u = ~req_wrap_u;
        req_wrap_v = ~req_wrap_v;
        req_filter = ~req_filter;
        req_u      = ~req_u;
        req_v      = req_v ^ {NL{32'hDEADBEEF}};
        req_du     = 32'h7FFF1234;
        req_dv     = 32'h80001234;
        req_tag    = 8'hEE;
    endtask

    // Called right after a falling edge; returns right after a falling edge in IDLE.
    task automatic run_req(input int i, input int hold);
        int s;
        int cyc;
        bit seen;
        logic [L-1:0]  snap_u0;
        logic [L-1:0]  snap_v1;
        logic [TW-1:0] snap_tag;
        s = vecs[i].filt ? 2 * NL : NL;
        if (hold > 0) rsp_ready = 1'b0;
        drive_fields(i);
        req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_wait", req_ready, 1'b1);
        @(posedge clk);
        exp_q.push_back({vecs[i].tag, vecs[i].eu0, vecs[i].ev0, vecs[i].eu1, vecs[i].ev1});
        @(negedge clk);
        req_valid = 1'b0;
        scramble_fields();
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                check("wrap_ready_busy", {req_ready, busy}, 2'b01);
                @(negedge clk);
                cyc++;
            end
        end
        check("rsp_seen", seen, 1'b1);
        if (seen) begin
            check("rsp_latency", cyc, s + 1);
            check("out_req_ready", req_ready, 1'b0);
            if (hold > 0) begin
                snap_u0  = rsp_u0;
                snap_v1  = rsp_v1;
                snap_tag = rsp_tag;
                drive_fields(0);
                req_valid = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    check("hold_valid_ready", {rsp_valid, req_ready}, 2'b10);
                    check("hold_u0",  rsp_u0,  snap_u0);
                    check("hold_v1",  rsp_v1,  snap_v1);
                    check("hold_tag", rsp_tag, snap_tag);
                end
                rsp_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            check("idle_after_rsp", {fsm_state, req_ready, rsp_valid}, {2'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        // Point REPEAT/REPEAT; du/dv nonzero but ignored in point mode
        set_vec(0, 2'd1, 2'd1, 1'b0,
                {32'h12345678, 32'h000ABCDE, 32'hFFFFF000, 32'h00180000},
                {32'h7FFFFFFF, 32'hFFF00000, 32'h00300001, 32'h00000000},
                32'h00050000, 32'h00050000, 8'h11,
                {20'h45678, 20'hABCDE, 20'hFF000, 20'h80000},
                {20'hFFFFF, 20'h00000, 20'h00001, 20'h00000},
                {20'h45678, 20'hABCDE, 20'hFF000, 20'h80000},
                {20'hFFFFF, 20'h00000, 20'h00001, 20'h00000});
        // Point CLAMP/CLAMP, including exactly 1.0 and the most negative value
        set_vec(1, 2'd0, 2'd0, 1'b0,
                {32'h00100000, 32'h000ABCDE, 32'h00180000, 32'hFFFFF000},
                {32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h000FFFFF},
                32'h0, 32'h0, 8'h22,
                {20'hFFFFF, 20'hABCDE, 20'hFFFFF, 20'h00000},
                {20'hFFFFF, 20'h00000, 20'h00000, 20'hFFFFF},
                {20'hFFFFF, 20'hABCDE, 20'hFFFFF, 20'h00000},
                {20'hFFFFF, 20'h00000, 20'h00000, 20'hFFFFF});
        // Point MIRROR on U, mode 3 on V
        set_vec(2, 2'd2, 2'd3, 1'b0,
                {32'h00200000, 32'hFFFFF000, 32'h00040000, 32'h00140000},
                {32'h00000123, 32'h00AB0000, 32'hFFFFF000, 32'h00140000},
                32'h0, 32'h0, 8'h33,
                {20'h00000, 20'h00FFF, 20'h40000, 20'hBFFFF},
                {20'h00123, 20'hB0000, 20'hFF000, 20'h40000},
                {20'h00000, 20'h00FFF, 20'h40000, 20'hBFFFF},
                {20'h00123, 20'hB0000, 20'hFF000, 20'h40000});
        // Bilinear REPEAT/REPEAT, negative dv and a signed overflow on lane 2
        set_vec(3, 2'd1, 2'd1, 1'b1,
                {32'hFFFE0000, 32'h7FFF0000, 32'h00000000, 32'h000F0000},
                {32'h00100000, 32'h00012345, 32'h00000000, 32'h00080000},
                32'h00020000, 32'hFFFF0000, 8'h44,
                {20'hE0000, 20'hF0000, 20'h00000, 20'hF0000},
                {20'h00000, 20'h12345, 20'h00000, 20'h80000},
                {20'h00000, 20'h10000, 20'h20000, 20'h10000},
                {20'hF0000, 20'h02345, 20'hF0000, 20'h70000});
        // Bilinear CLAMP on U, MIRROR on V
        set_vec(4, 2'd0, 2'd2, 1'b1,
                {32'h80000000, 32'h00000000, 32'hFFFF8000, 32'h000F8000},
                {32'hFFF80000, 32'h00100000, 32'h000C0000, 32'h00000000},
                32'h00010000, 32'h00080000, 8'h55,
                {20'h00000, 20'h00000, 20'h00000, 20'hF8000},
                {20'h7FFFF, 20'hFFFFF, 20'hC0000, 20'h00000},
                {20'h00000, 20'h10000, 20'h08000, 20'hFFFFF},
                {20'h00000, 20'h7FFFF, 20'hBFFFF, 20'h80000});
        // Point REPEAT on U, CLAMP on V, used after the mid-flight reset
        set_vec(5, 2'd1, 2'd0, 1'b0,
                {32'hFFFFFFFF, 32'h00000000, 32'h00FEDCBA, 32'h00012345},
                {32'h000FFFFF, 32'h01000000, 32'hFFFFFFFF, 32'h00050000},
                32'h0, 32'h0, 8'h77,
                {20'hFFFFF, 20'h00000, 20'hEDCBA, 20'h12345},
                {20'hFFFFF, 20'hFFFFF, 20'h00000, 20'h50000},
                {20'hFFFFF, 20'h00000, 20'hEDCBA, 20'h12345},
                {20'hFFFFF, 20'hFFFFF, 20'h00000, 20'h50000});

        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drive_fields(0);
        repeat (3) @(negedge clk);
        check("reset_ctrl", {fsm_state, req_ready, rsp_valid, busy}, {2'd0, 1'b1, 1'b0, 1'b0});
        check("reset_data", {rsp_u0, rsp_v1, rsp_tag}, '0);
        reset_n = 1'b1;
        @(negedge clk);

        run_req(0, 0);
        run_req(1, 0);
        run_req(2, 0);
        run_req(3, 0);
        run_req(4, 5);
        run_req(0, 0);

        // Reset in the middle of a bilinear WRAP sweep
        drive_fields(3);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("busy_mid_wrap", {busy, fsm_state}, {1'b1, 2'd1});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", {fsm_state, req_ready, rsp_valid, busy}, {2'd0, 1'b1, 1'b0, 1'b0});
        check("async_reset_u0", rsp_u0, '0);
        check("async_reset_v0", rsp_v0, '0);
        check("async_reset_u1v1", {rsp_u1, rsp_v1}, '0);
        check("async_reset_tag", rsp_tag, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("post_reset_idle", {req_ready, rsp_valid}, 2'b10);
        end
        run_req(5, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
